id_issue_controller: RTL and testbench

Sequencing controller for the Instruction Decode stage of the 5-stage RV32 pipeline. It owns the IF/ID pipeline register, decodes source-register usage from the opcode, and detects load-use hazards against the instruction in EX. It issues instructions into ID/EX or inserts a bubble, flushes on branch/jump redirect, and maintains saturating stall and flush counters.

---
 rtl/id_issue_controller.sv | 166 ++++++++++++++++
 tb/tb_id_issue_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_controller.sv
// Instruction Decode sequencing: IF/ID register, load-use hazard detection against EX,
// issue/bubble/flush control, and saturating stall/flush performance counters.
module id_issue_controller #(
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    input  logic [INSTR_WIDTH-1:0] if_instr,
    input  logic [INSTR_WIDTH-1:0] if_pc,
    output logic                   if_ready,
    input  logic                   ex_ready,
    input  logic                   redirect,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [INSTR_WIDTH-1:0] id_pc,
    output logic                   issue_valid,
    output logic                   bubble,
    output logic                   stall,
    input  logic                   perf_clr,
    output logic [CNT_WIDTH-1:0]   stall_cycles,
    output logic [CNT_WIDTH-1:0]   flush_count
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [INSTR_WIDTH-1:0]    INSTR_ZERO = {INSTR_WIDTH{1'b0}};
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO   = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic                      id_valid_r;
    logic [INSTR_WIDTH-1:0]    id_instr_r;
    logic [INSTR_WIDTH-1:0]    id_pc_r;
    logic                      ex_load_valid_r;
    logic [REG_ADDR_WIDTH-1:0] ex_load_rd_r;
    logic [CNT_WIDTH-1:0]      stall_cycles_r;
    logic [CNT_WIDTH-1:0]      flush_count_r;

    logic [6:0]                opcode_s;
    logic [2:0]                funct3_s;
    logic [REG_ADDR_WIDTH-1:0] rd_s;
    logic [REG_ADDR_WIDTH-1:0] rs1_s;
    logic [REG_ADDR_WIDTH-1:0] rs2_s;
    logic                      rs1_used_s;
    logic                      rs2_used_s;
    logic                      hazard_s;
    logic                      stall_s;
    logic                      issue_fire_s;
    logic                      if_ready_s;

    assign opcode_s = id_instr_r[6:0];
    assign funct3_s = id_instr_r[14:12];
    assign rd_s     = id_instr_r[7 +: REG_ADDR_WIDTH];
    assign rs1_s    = id_instr_r[15 +: REG_ADDR_WIDTH];
    assign rs2_s    = id_instr_r[20 +: REG_ADDR_WIDTH];

    // Source-register usage decode; CSR immediate forms carry a uimm in the rs1 field.
    always_comb begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        case (opcode_s)
            OP_OP, OP_STORE, OP_BRANCH: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                rs1_used_s = 1'b1;
            end
            OP_SYSTEM: begin
                rs1_used_s = ~funct3_s[2] & (funct3_s != 3'b000);
            end
            default: begin
                rs1_used_s = 1'b0;
                rs2_used_s = 1'b0;
            end
        endcase
    end

    assign hazard_s     = id_valid_r & ex_load_valid_r &
                          ((rs1_used_s & (rs1_s == ex_load_rd_r)) |
                           (rs2_used_s & (rs2_s == ex_load_rd_r)));
    assign stall_s      = hazard_s & ~redirect;
    assign issue_fire_s = id_valid_r & ~hazard_s & ex_ready & ~redirect;
    assign if_ready_s   = ~id_valid_r | issue_fire_s | redirect;

    // IF/ID register: redirect squashes, capture refills, issue drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_r <= 1'b0;
            id_instr_r <= INSTR_ZERO;
            id_pc_r    <= INSTR_ZERO;
        end else if (redirect) begin
            id_valid_r <= 1'b0;
        end else if (if_valid && if_ready_s) begin
            id_valid_r <= 1'b1;
            id_instr_r <= if_instr;
            id_pc_r    <= if_pc;
        end else if (issue_fire_s) begin
            id_valid_r <= 1'b0;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    // Tracks a load currently in EX; x0 destinations are never recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_load_valid_r <= 1'b0;
            ex_load_rd_r    <= REG_ZERO;
        end else if (redirect) begin
            ex_load_valid_r <= 1'b0;
        end else if (ex_ready) begin
            if (issue_fire_s && (opcode_s == OP_LOAD) && (rd_s != REG_ZERO)) begin
                ex_load_valid_r <= 1'b1;
                ex_load_rd_r    <= rd_s;
            end else begin
                ex_load_valid_r <= 1'b0;
            end
        end else begin
            ex_load_valid_r <= ex_load_valid_r;
        end
    end

    // Saturating performance counters with clear priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= CNT_ZERO;
            flush_count_r  <= CNT_ZERO;
        end else if (perf_clr) begin
            stall_cycles_r <= CNT_ZERO;
            flush_count_r  <= CNT_ZERO;
        end else begin
            if (stall_s && ex_ready && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (redirect && id_valid_r && (flush_count_r != CNT_MAX)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign if_ready     = if_ready_s;
    assign id_valid     = id_valid_r;
    assign id_instr     = id_instr_r;
    assign id_pc        = id_pc_r;
    assign issue_valid  = issue_fire_s;
    assign bubble       = ex_ready & ~issue_fire_s;
    assign stall        = stall_s;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_id_issue_controller.sv
// Directed self-checking bench for id_issue_controller; counters built 8 bits wide
// so saturation is reachable in a short run.
module tb_id_issue_controller;

    localparam int CW = 8;

    localparam logic [31:0] ADDI1   = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] ADDI2   = 32'h00200113; // addi x2,x0,2
    localparam logic [31:0] LW5     = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] ADD655  = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] LW0     = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD600  = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] LUI5    = 32'h123452B7; // lui x5,0x12345
    localparam logic [31:0] CSRRW5  = 32'h00029073; // csrrw x0,0,x5
    localparam logic [31:0] CSRRWI5 = 32'h0002D073; // csrrwi x0,0,5
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] SW5     = 32'h00512023; // sw x5,0(x2)
    localparam logic [31:0] LWCHAIN = 32'h0002A283; // lw x5,0(x5)

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic          if_ready;
    logic          ex_ready;
    logic          redirect;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [31:0]   id_pc;
    logic          issue_valid;
    logic          bubble;
    logic          stall;
    logic          perf_clr;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;

    int err_cnt = 0;
    int chk_cnt = 0;
    int exp_sc  = 0;

    always #5 clk = ~clk;

    id_issue_controller #(.INSTR_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .ex_ready(ex_ready), .redirect(redirect), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .issue_valid(issue_valid), .bubble(bubble),
        .stall(stall), .perf_clr(perf_clr), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        #1;
    endtask

    // Load x5 followed by nxt; expects a single bubble only when nxt reads x5.
    task automatic load_then(input logic [31:0] nxt, input logic exp_stall, input string tag);
        feed(LW5, 32'h100);
        tick();
        feed(nxt, 32'h104);
        tick();
        idle();
        check_eq({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        if (exp_stall) begin
            tick();
            exp_sc++;
        end
        check_eq({tag, "_issue"}, 32'(issue_valid), 32'd1);
        check_eq({tag, "_sc"}, 32'(stall_cycles), 32'(exp_sc));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        ex_ready = 1'b0; redirect = 1'b0; perf_clr = 1'b0;
        #12;
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_if_ready", 32'(if_ready), 32'd1);
        check_eq("rst_issue", 32'(issue_valid), 32'd0);
        check_eq("rst_bubble", 32'(bubble), 32'd0);
        check_eq("rst_id_instr", id_instr, 32'd0);
        check_eq("rst_sc", 32'(stall_cycles), 32'd0);
        rst_n = 1'b1;
        ex_ready = 1'b1;
        tick();

        // independent stream
        feed(ADDI1, 32'h0);
        check_eq("ind_first_issue", 32'(issue_valid), 32'd0);
        tick();
        feed(ADDI2, 32'h4);
        check_eq("ind_issue0", 32'(issue_valid), 32'd1);
        check_eq("ind_pc0", id_pc, 32'h0);
        check_eq("ind_bubble0", 32'(bubble), 32'd0);
        check_eq("ind_ready0", 32'(if_ready), 32'd1);
        tick();
        idle();
        check_eq("ind_issue1", 32'(issue_valid), 32'd1);
        check_eq("ind_pc1", id_pc, 32'h4);
        check_eq("ind_bubble1", 32'(bubble), 32'd0);
        tick();
        check_eq("ind_drain", 32'(id_valid), 32'd0);
        check_eq("ind_sc", 32'(stall_cycles), 32'd0);

        // load-use
        feed(LW5, 32'h8);
        tick();
        feed(ADD655, 32'hC);
        check_eq("lu_lw_issue", 32'(issue_valid), 32'd1);
        tick();
        idle();
        check_eq("lu_stall", 32'(stall), 32'd1);
        check_eq("lu_bubble", 32'(bubble), 32'd1);
        check_eq("lu_if_ready", 32'(if_ready), 32'd0);
        check_eq("lu_no_issue", 32'(issue_valid), 32'd0);
        check_eq("lu_held", id_instr, ADD655);
        tick();
        exp_sc = 1;
        check_eq("lu_stall_end", 32'(stall), 32'd0);
        check_eq("lu_add_issue", 32'(issue_valid), 32'd1);
        check_eq("lu_sc", 32'(stall_cycles), 32'd1);
        tick();
        check_eq("lu_drain", 32'(id_valid), 32'd0);

        // no false hazards
        feed(LW0, 32'h10);
        tick();
        feed(ADD600, 32'h14);
        tick();
        idle();
        check_eq("x0_stall", 32'(stall), 32'd0);
        check_eq("x0_issue", 32'(issue_valid), 32'd1);
        tick();
        load_then(LUI5, 1'b0, "lui");
        load_then(CSRRW5, 1'b1, "csrrw");
        load_then(CSRRWI5, 1'b0, "csrrwi");

        // redirect
        feed(NOP, 32'h8);
        tick();
        redirect = 1'b1;
        feed(ADDI1, 32'hC);
        check_eq("rd_issue", 32'(issue_valid), 32'd0);
        check_eq("rd_bubble", 32'(bubble), 32'd1);
        check_eq("rd_if_ready", 32'(if_ready), 32'd1);
        tick();
        idle();
        check_eq("rd_dropped", 32'(id_valid), 32'd0);
        check_eq("rd_fc", 32'(flush_count), 32'd1);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("rd_empty_fc", 32'(flush_count), 32'd1);

        // redirect overrides a pending hazard and clears the load tracker
        feed(LW5, 32'h20);
        tick();
        feed(ADD655, 32'h24);
        tick();
        idle();
        redirect = 1'b1;
        #1;
        check_eq("rdh_stall", 32'(stall), 32'd0);
        check_eq("rdh_bubble", 32'(bubble), 32'd1);
        tick();
        redirect = 1'b0;
        check_eq("rdh_fc", 32'(flush_count), 32'd2);
        feed(ADD655, 32'h30);
        tick();
        idle();
        check_eq("rdh_tracker_clr", 32'(stall), 32'd0);
        check_eq("rdh_issue", 32'(issue_valid), 32'd1);
        tick();

        // backpressure with dependent store held in ID
        feed(LW5, 32'h40);
        tick();
        feed(SW5, 32'h44);
        tick();
        idle();
        ex_ready = 1'b0;
        #1;
        check_eq("bp_stall0", 32'(stall), 32'd1);
        check_eq("bp_bubble0", 32'(bubble), 32'd0);
        check_eq("bp_held0", id_instr, SW5);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bp_stall", 32'(stall), 32'd1);
            check_eq("bp_held", id_instr, SW5);
            check_eq("bp_sc_hold", 32'(stall_cycles), 32'(exp_sc));
        end
        ex_ready = 1'b1;
        #1;
        check_eq("bp_bubble", 32'(bubble), 32'd1);
        tick();
        exp_sc++;
        check_eq("bp_issue", 32'(issue_valid), 32'd1);
        check_eq("bp_sc", 32'(stall_cycles), 32'(exp_sc));
        tick();
        check_eq("bp_drain", 32'(id_valid), 32'd0);

        // saturation, clear, asynchronous reset mid-stall
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check_eq("clr_sc", 32'(stall_cycles), 32'd0);
        check_eq("clr_fc", 32'(flush_count), 32'd0);
        feed(LWCHAIN, 32'h80);
        repeat (21) tick();
        check_eq("chain_sc", 32'(stall_cycles), 32'd10);
        repeat (600) tick();
        check_eq("sat_sc", 32'(stall_cycles), 32'hFF);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check_eq("sat_clr", 32'(stall_cycles), 32'd0);
        for (int i = 0; i < 4 && !stall; i++) tick();
        check_eq("wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_id_valid", 32'(id_valid), 32'd0);
        check_eq("arst_if_ready", 32'(if_ready), 32'd1);
        check_eq("arst_stall", 32'(stall), 32'd0);
        if_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_valid", 32'(id_valid), 32'd0);
        tick();
        check_eq("post_rst_idle", 32'(id_valid), 32'd0);
        check_eq("post_rst_issue", 32'(issue_valid), 32'd0);
        check_eq("post_rst_sc", 32'(stall_cycles), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
